mem_arbiter: RTL and testbench

Arbiter that shares the single 16-bit unified memory port between the instruction-fetch requester (PC from `addr_ctrl`) and the data requester (load/store/pop). Data accesses get priority; a streak counter guarantees fetch progress. The block issues at most one access per cycle, tracks the owner of each in-flight read and routes the read data back to that requester. It sits between `addr_ctrl`/core pipeline and the memory macro.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_prio.sv | 53 +++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory port arbiter.
//   owner_t  : owner of the read currently in flight (none / fetch / data)
//   WORD_W   : memory word width in bits
//   STREAK_W : width of the data-grant streak counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// -----------------------------------------------------------------------------
// mem_arb_prio
// Grant selection between fetch and data requesters. Data wins by default; a
// streak counter lets fetch through once MAX_STREAK data grants have been
// given back to back while fetch was waiting.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   i_if_req         : fetch request (already qualified by reset)
//   i_d_req          : data request  (already qualified by reset)
//   o_if_gnt         : fetch granted this cycle
//   o_d_gnt          : data granted this cycle
// -----------------------------------------------------------------------------
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_if_gnt,
    output logic o_d_gnt
);

    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_nxt;
    logic                w_sat;

    assign w_sat = (r_streak == STREAK_W'(MAX_STREAK));

    always_comb begin
        o_d_gnt      = i_d_req && !(i_if_req && w_sat);
        o_if_gnt     = i_if_req && !o_d_gnt;
        w_streak_nxt = r_streak;
        // Streak only measures how long fetch has been starved; any fetch
        // grant or an idle fetch side restarts it.
        if (o_if_gnt || !i_if_req) begin
            w_streak_nxt = '0;
        end else if (o_d_gnt && !w_sat) begin
            w_streak_nxt = r_streak + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else begin
            r_streak <= w_streak_nxt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single 16-bit unified memory port between instruction fetch and
// data (load/store/pop). At most one access is issued per cycle; the owner of
// each read is remembered for one cycle so the read data is flagged valid to
// the right requester.
// Optional feature: define MEM_ARB_ALIGN_CHK_EN to suppress odd-address
// accesses (granted but not issued); a suppressed data access raises o_d_err
// one cycle after its grant. Without it, address bit 0 is simply dropped.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   i_if_req/i_if_addr              : fetch request and byte address
//   o_if_gnt/o_if_rvalid/o_if_rdata : fetch grant and returned read data
//   i_d_req/i_d_we/i_d_addr/i_d_wdata : data request, write flag, address, data
//   o_d_gnt/o_d_rvalid/o_d_rdata    : data grant and returned read data
//   o_d_err                         : misaligned data access flag
//   o_mem_en/o_mem_we/o_mem_addr    : memory strobe, write enable, word address
//   i_mem_rdata                     : memory read data (one cycle after read)
// Write data reaches the memory macro directly from i_d_wdata.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH  = 4096,
    parameter  int unsigned MAX_STREAK = 4,
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH * 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [WORD_W-1:0]     o_if_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [WORD_W-1:0]     i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [WORD_W-1:0]     o_d_rdata,
    output logic                  o_d_err,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-2:0] o_mem_addr,
    input  logic [WORD_W-1:0]     i_mem_rdata
);

    logic                  w_if_req;
    logic                  w_d_req;
    logic                  w_if_gnt;
    logic                  w_d_gnt;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic                  w_odd;
    logic                  w_issue;
    owner_t                w_own_nxt;
    owner_t                r_rd_own;

    // Requests are masked while reset is low so no grant or strobe escapes.
    assign w_if_req = i_if_req & rst;
    assign w_d_req  = i_d_req & rst;

    mem_arb_prio #(
        .MAX_STREAK(MAX_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .i_if_req (w_if_req),
        .i_d_req  (w_d_req),
        .o_if_gnt (w_if_gnt),
        .o_d_gnt  (w_d_gnt)
    );

    assign o_if_gnt   = w_if_gnt;
    assign o_d_gnt    = w_d_gnt;
    assign w_addr_sel = w_d_gnt ? i_d_addr : i_if_addr;

`ifdef MEM_ARB_ALIGN_CHK_EN
    logic r_d_err;
    logic w_unused;

    assign w_odd    = w_addr_sel[0];
    assign w_unused = ^i_d_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d_err <= 1'b0;
        end else begin
            r_d_err <= w_d_gnt & w_odd;
        end
    end

    assign o_d_err = r_d_err;
`else
    logic w_unused;

    assign w_odd    = 1'b0;
    assign w_unused = ^{i_d_wdata, w_addr_sel[0]};
    assign o_d_err  = 1'b0;
`endif

    // A grant on an odd address (alignment check enabled) is consumed
    // without touching memory.
    assign w_issue    = (w_d_gnt | w_if_gnt) & ~w_odd;
    assign o_mem_en   = w_issue;
    assign o_mem_we   = w_issue & w_d_gnt & i_d_we;
    assign o_mem_addr = w_issue ? w_addr_sel[ADDR_WIDTH-1:1] : '0;

    always_comb begin
        w_own_nxt = OWN_NONE;
        if (w_issue && w_if_gnt) begin
            w_own_nxt = OWN_IF;
        end else if (w_issue && w_d_gnt && !i_d_we) begin
            w_own_nxt = OWN_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_own <= OWN_NONE;
        end else begin
            r_rd_own <= w_own_nxt;
        end
    end

    assign o_if_rvalid = (r_rd_own == OWN_IF);
    assign o_d_rvalid  = (r_rd_own == OWN_DATA);
    assign o_if_rdata  = rst ? i_mem_rdata : '0;
    assign o_d_rdata   = rst ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural memory macro and a
// scoreboard of expected read returns.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned AW    = 13;

    typedef struct {
        owner_t      own;
        logic [15:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt;
    logic          o_if_rvalid;
    logic [15:0]   o_if_rdata;
    logic          i_d_req;
    logic          i_d_we;
    logic [AW-1:0] i_d_addr;
    logic [15:0]   i_d_wdata;
    logic          o_d_gnt;
    logic          o_d_rvalid;
    logic [15:0]   o_d_rdata;
    logic          o_d_err;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW-2:0] o_mem_addr;
    logic [15:0]   i_mem_rdata;

    logic [15:0] mem     [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    exp_t        sb[$];
    int          tests;
    int          fails;

    mem_arbiter #(
        .MEM_DEPTH (DEPTH),
        .MAX_STREAK(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .o_if_gnt   (o_if_gnt),
        .o_if_rvalid(o_if_rvalid),
        .o_if_rdata (o_if_rdata),
        .i_d_req    (i_d_req),
        .i_d_we     (i_d_we),
        .i_d_addr   (i_d_addr),
        .i_d_wdata  (i_d_wdata),
        .o_d_gnt    (o_d_gnt),
        .o_d_rvalid (o_d_rvalid),
        .o_d_rdata  (o_d_rdata),
        .o_d_err    (o_d_err),
        .o_mem_en   (o_mem_en),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .i_mem_rdata(i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr] <= i_d_wdata;
            else          i_mem_rdata     <= mem[o_mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then compare read returns against the scoreboard.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rv_if", 32'(o_if_rvalid), 32'(e.own == OWN_IF));
            check("rv_d", 32'(o_d_rvalid), 32'(e.own == OWN_DATA));
            check("rdata", 32'((e.own == OWN_IF) ? o_if_rdata : o_d_rdata), 32'(e.data));
        end else begin
            check("rv_none", 32'({o_if_rvalid, o_d_rvalid}), 32'(0));
        end
    endtask

    initial begin
        logic [9:0] pat;
        tests = 0;
        fails = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = 16'(i) ^ 16'hA5C3;
            ref_mem[i] = 16'(i) ^ 16'hA5C3;
        end
        rst = 1'b0; i_if_req = 1'b1; i_d_req = 1'b1; i_d_we = 1'b0;
        i_if_addr = 13'h0010; i_d_addr = 13'h0040; i_d_wdata = '0;

        // Reset with both requests high
        #2;
        check("rst_if_gnt", 32'(o_if_gnt), 0);
        check("rst_d_gnt", 32'(o_d_gnt), 0);
        check("rst_mem_en", 32'(o_mem_en), 0);
        check("rst_rvalid", 32'({o_if_rvalid, o_d_rvalid}), 0);
        check("rst_d_err", 32'(o_d_err), 0);
        @(posedge clk); #1;

        // Release: data wins first
        rst = 1'b1; #1;
        check("rel_d_gnt", 32'(o_d_gnt), 1);
        check("rel_if_gnt", 32'(o_if_gnt), 0);
        check("rel_addr", 32'(o_mem_addr), 32'h020);
        sb.push_back('{OWN_DATA, ref_mem[12'h020]});
        cycle();

        // Fetch only, 0x0014
        i_d_req = 1'b0; i_if_addr = 13'h0014; #1;
        check("f_gnt", 32'(o_if_gnt), 1);
        check("f_addr", 32'(o_mem_addr), 32'h00A);
        check("f_we", 32'(o_mem_we), 0);
        sb.push_back('{OWN_IF, ref_mem[12'h00A]});
        cycle();

        // Both held 10 cycles: D,D,D,D,F,D,D,D,D,F (1 = data)
        pat = 10'b0111101111;
        i_d_req = 1'b1; i_d_addr = 13'h0100; i_if_addr = 13'h0200;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("pat_d", 32'(o_d_gnt), 32'(pat[k]));
            check("pat_if", 32'(o_if_gnt), 32'(!pat[k]));
            if (pat[k]) sb.push_back('{OWN_DATA, ref_mem[12'h080]});
            else        sb.push_back('{OWN_IF, ref_mem[12'h100]});
            cycle();
        end

        // Write 0x1234 to 0x0020, then fetch it back
        i_if_req = 1'b0; i_d_we = 1'b1; i_d_addr = 13'h0020; i_d_wdata = 16'h1234; #1;
        check("w_gnt", 32'(o_d_gnt), 1);
        check("w_we", 32'(o_mem_we), 1);
        check("w_addr", 32'(o_mem_addr), 32'h010);
        ref_mem[12'h010] = 16'h1234;
        cycle();
        i_d_req = 1'b0; i_d_we = 1'b0; i_if_req = 1'b1; i_if_addr = 13'h0020; #1;
        check("wf_gnt", 32'(o_if_gnt), 1);
        sb.push_back('{OWN_IF, ref_mem[12'h010]});
        cycle();

        // Top of memory
        i_if_req = 1'b0; i_d_req = 1'b1; i_d_addr = 13'h1FFE; #1;
        check("top_addr", 32'(o_mem_addr), 32'hFFF);
        sb.push_back('{OWN_DATA, ref_mem[12'hFFF]});
        cycle();

        // Reset right after a data read grant: no rvalid
        i_d_addr = 13'h0030; #1;
        check("rr_gnt", 32'(o_d_gnt), 1);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check("rr_rvalid", 32'(o_d_rvalid), 0);
        check("rr_gnt_forced", 32'(o_d_gnt), 0);
        @(posedge clk); #1;
        check("rr_rvalid2", 32'(o_d_rvalid), 0);
        i_d_req = 1'b0; rst = 1'b1; #1;
        cycle();

        // Odd data address 0x0005
        i_d_req = 1'b1; i_d_addr = 13'h0005; #1;
        check("odd_gnt", 32'(o_d_gnt), 1);
`ifdef MEM_ARB_ALIGN_CHK_EN
        check("odd_en", 32'(o_mem_en), 0);
        cycle();
        check("odd_err", 32'(o_d_err), 1);
`else
        check("odd_addr", 32'(o_mem_addr), 32'h002);
        sb.push_back('{OWN_DATA, ref_mem[12'h002]});
        cycle();
        check("odd_err", 32'(o_d_err), 0);
`endif
        i_d_req = 1'b0; #1;
        cycle();
        check("idle_err", 32'(o_d_err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
